// File: rtl/alien_pkg.sv
// Shared types, widths and sprite artwork for the alien unit.
package alien_pkg;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        EXPLODING = 2'd1,
        DEAD      = 2'd2
    } alien_state_t;

    localparam int POS_W = 16;

    // Built-in artwork: up to 16x16 texels, column 0 is the MSB of a row.
    // kind 0/1 are the two walk frames, kind 2 is the explosion burst.
    function automatic logic [15:0] sprite_row(input logic [1:0] kind, input logic [3:0] row);
        logic [15:0] r;
        r = '0;
        if (kind == 2'd2) begin
            case (row)
                4'd1:    r = 16'b0001000100010000;
                4'd3:    r = 16'b0100100100100100;
                4'd5:    r = 16'b1001001001001001;
                4'd7:    r = 16'b0010010010010010;
                4'd9:    r = 16'b1000100010001000;
                4'd11:   r = 16'b0001000100010000;
                default: r = '0;
            endcase
        end else begin
            case (row)
                4'd0:    r = 16'b0000011111100000;
                4'd1:    r = 16'b0001111111111000;
                4'd2:    r = 16'b0011111111111100;
                4'd3:    r = 16'b0111001111001110;
                4'd4:    r = 16'b0111001111001110;
                4'd5:    r = kind[0] ? 16'b0100111111110010 : 16'b0111111111111110;
                4'd6:    r = 16'b0001111001111000;
                4'd7:    r = kind[0] ? 16'b0110011001100110 : 16'b0011100000011100;
                4'd8:    r = kind[0] ? 16'b0001100000011000 : 16'b0110000000000110;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/alien_sprite_rom.sv
// Combinational sprite ROM: NUM_FRAMES walk frames plus one explosion frame
// (frame index NUM_FRAMES), addressed by frame, texel row and texel column.
module alien_sprite_rom
    import alien_pkg::*;
#(
    parameter int NUM_FRAMES = 2,
    parameter int SPR_W      = 16,
    parameter int SPR_H      = 16,
    parameter int AW         = 2,
    parameter int RW         = 4,
    parameter int CLW        = 4
) (
    input  logic [AW-1:0]  frame_i,
    input  logic [RW-1:0]  row_i,
    input  logic [CLW-1:0] col_i,
    output logic           bit_o
);

    logic [31:0] frame_ext;
    logic [31:0] row_ext;
    logic [31:0] col_ext;
    logic [1:0]  kind;
    logic [15:0] row_bits;

    assign frame_ext = 32'(frame_i);
    assign row_ext   = 32'(row_i);
    assign col_ext   = 32'(col_i);

    // Frames past the walk cycle select the explosion art; texels beyond the
    // 16x16 artwork read as transparent.
    always_comb begin
        kind     = (frame_ext >= 32'(NUM_FRAMES)) ? 2'd2 : {1'b0, frame_i[0]};
        row_bits = '0;
        bit_o    = 1'b0;
        if (row_ext < 32'd16 && row_ext < 32'(SPR_H)) begin
            row_bits = sprite_row(kind, row_ext[3:0]);
        end
        if (col_ext < 32'd16 && col_ext < 32'(SPR_W)) begin
            bit_o = row_bits[4'(32'd15 - col_ext)];
        end
    end

endmodule

// File: rtl/alien_unit.sv
// One formation alien: step-timed motion, descend, alive/exploding/dead FSM,
// fire-request handshake with cooldown and a registered sprite pixel.
//
// Handshake: fire_req is a level request held until the cycle in which
// fire_req & fire_ack are both high; that cycle completes the transfer, the
// request drops on the next cycle and the cooldown restarts. fire_ack seen
// while fire_req is low has no effect.
module alien_unit
    import alien_pkg::*;
#(
    parameter int INIT_X         = 0,
    parameter int INIT_Y         = 0,
    parameter int MIN_X          = 0,
    parameter int MAX_X          = 640,
    parameter int SPR_W          = 16,
    parameter int SPR_H          = 16,
    parameter int SCALE_LOG2     = 2,
    parameter int NUM_FRAMES     = 2,
    parameter int DROP_DY        = 16,
    parameter int EXPLODE_CYCLES = 8,
    parameter int FIRE_COOLDOWN  = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [POS_W-1:0] step_period,
    input  logic [POS_W-1:0] step_dx,
    input  logic             dir_right,
    input  logic             descend,
    input  logic             hit,
    input  logic             armed,
    input  logic             fire_ack,
    input  logic [POS_W-1:0] scan_x,
    input  logic [POS_W-1:0] scan_y,
    output logic             pixel,
    output logic             edge_hit,
    output logic             fire_req,
    output logic [POS_W-1:0] shot_x,
    output logic [POS_W-1:0] shot_y,
    output logic             alive,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output alien_state_t     dbg_state_o,
    output logic [7:0]       dbg_frame_o
);

    localparam int SPR_PIX_W = SPR_W << SCALE_LOG2;
    localparam int SPR_PIX_H = SPR_H << SCALE_LOG2;
    localparam logic [POS_W-1:0] X_LO = POS_W'(MIN_X);
    localparam logic [POS_W-1:0] X_HI = POS_W'(MAX_X - SPR_PIX_W);
    localparam int FW  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int AW  = $clog2(NUM_FRAMES + 1);
    localparam int EW  = (EXPLODE_CYCLES > 1) ? $clog2(EXPLODE_CYCLES + 1) : 1;
    localparam int CW  = $clog2(FIRE_COOLDOWN + 1);
    localparam int RW  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int CLW = (SPR_W > 1) ? $clog2(SPR_W) : 1;

    alien_state_t     state_q;
    logic [EW-1:0]    expl_cnt_q;
    logic             fire_req_q;
    logic [CW-1:0]    cooldown_q;

    logic [POS_W-1:0] step_cnt_q, step_cnt_d;
    logic [POS_W-1:0] pos_x_q, pos_x_d;
    logic [POS_W-1:0] pos_y_q, pos_y_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic             edge_hit_q, edge_hit_d;
    logic             pixel_q, pixel_d;

    logic             tick;
    logic             is_alive;
    logic [POS_W:0]   sum_r;
    logic [POS_W:0]   diff_l;
    logic [POS_W-1:0] right_x;
    logic [POS_W-1:0] left_x;
    logic [POS_W-1:0] new_x;

    logic [POS_W-1:0] off_x, off_y;
    logic [POS_W-1:0] rel_x, rel_y;
    logic             in_box;
    logic [AW-1:0]    rom_frame;
    logic             rom_bit;

    assign is_alive = (state_q == ALIVE);

    // Step timer: free-running in every state, ticks once it reaches step_period.
    // Using >= keeps a lowered step_period from waiting for a 16-bit wrap.
    always_comb begin
        tick       = (step_cnt_q >= step_period);
        step_cnt_d = tick ? '0 : step_cnt_q + POS_W'(1);
    end

    // Horizontal/vertical motion and animation frame, only while alive.
    always_comb begin
        sum_r      = {1'b0, pos_x_q} + {1'b0, step_dx};
        diff_l     = {1'b0, pos_x_q} - {1'b0, step_dx};
        right_x    = (sum_r >= {1'b0, X_HI}) ? X_HI : sum_r[POS_W-1:0];
        left_x     = (diff_l[POS_W] || (diff_l[POS_W-1:0] <= X_LO)) ? X_LO : diff_l[POS_W-1:0];
        new_x      = dir_right ? right_x : left_x;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        frame_d    = frame_q;
        edge_hit_d = 1'b0;
        if (is_alive && tick) begin
            pos_x_d    = new_x;
            frame_d    = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + FW'(1);
            edge_hit_d = (new_x == X_LO) || (new_x == X_HI);
        end
        if (is_alive && descend) begin
            pos_y_d = pos_y_q + POS_W'(DROP_DY);
        end
    end

    // Sprite lookup: beam offset scaled down to texels; a negative offset
    // wraps to a large value and is rejected by the scan>=pos test.
    always_comb begin
        off_x     = scan_x - pos_x_q;
        off_y     = scan_y - pos_y_q;
        rel_x     = off_x >> SCALE_LOG2;
        rel_y     = off_y >> SCALE_LOG2;
        in_box    = (scan_x >= pos_x_q) && (scan_y >= pos_y_q) &&
                    (rel_x < POS_W'(SPR_W)) && (rel_y < POS_W'(SPR_H));
        rom_frame = (state_q == EXPLODING) ? AW'(NUM_FRAMES) : AW'(frame_q);
        pixel_d   = in_box && (state_q != DEAD) && rom_bit;
    end

    alien_sprite_rom #(
        .NUM_FRAMES (NUM_FRAMES),
        .SPR_W      (SPR_W),
        .SPR_H      (SPR_H),
        .AW         (AW),
        .RW         (RW),
        .CLW        (CLW)
    ) u_rom (
        .frame_i (rom_frame),
        .row_i   (rel_y[RW-1:0]),
        .col_i   (rel_x[CLW-1:0]),
        .bit_o   (rom_bit)
    );

    // Datapath registers: timer, position, frame, edge pulse and pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_q <= '0;
            pos_x_q    <= POS_W'(INIT_X);
            pos_y_q    <= POS_W'(INIT_Y);
            frame_q    <= '0;
            edge_hit_q <= 1'b0;
            pixel_q    <= 1'b0;
        end else begin
            step_cnt_q <= step_cnt_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            frame_q    <= frame_d;
            edge_hit_q <= edge_hit_d;
            pixel_q    <= pixel_d;
        end
    end

    // Life-cycle FSM with the fire request and its cooldown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ALIVE;
            expl_cnt_q <= '0;
            fire_req_q <= 1'b0;
            cooldown_q <= '0;
        end else begin
            if (cooldown_q != '0) begin
                cooldown_q <= cooldown_q - CW'(1);
            end
            case (state_q)
                ALIVE: begin
                    if (hit) begin
                        state_q    <= EXPLODING;
                        expl_cnt_q <= '0;
                        fire_req_q <= 1'b0;
                    end else if (fire_req_q && fire_ack) begin
                        fire_req_q <= 1'b0;
                        cooldown_q <= CW'(FIRE_COOLDOWN);
                    end else if (!fire_req_q && armed && (cooldown_q == '0)) begin
                        fire_req_q <= 1'b1;
                    end
                end
                EXPLODING: begin
                    fire_req_q <= 1'b0;
                    if (tick) begin
                        if ((32'(expl_cnt_q) + 32'd1) >= 32'(EXPLODE_CYCLES)) begin
                            state_q <= DEAD;
                        end else begin
                            expl_cnt_q <= expl_cnt_q + EW'(1);
                        end
                    end
                end
                DEAD: begin
                    fire_req_q <= 1'b0;
                end
                default: begin
                    state_q    <= DEAD;
                    fire_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign pixel       = pixel_q;
    assign edge_hit    = edge_hit_q;
    assign fire_req    = fire_req_q;
    assign alive       = is_alive;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign shot_x      = pos_x_q + POS_W'(SPR_PIX_W / 2);
    assign shot_y      = pos_y_q + POS_W'(SPR_PIX_H);
    assign dbg_state_o = state_q;
    assign dbg_frame_o = 8'(frame_q);

endmodule

// File: tb/tb_alien_unit.sv
// Bench for alien_unit placed at (560,32) so the right bound (576) is a few
// steps away. Edge pulses and fire-request rises are predicted into queues by
// the stimulus thread and popped by a monitor when the DUT shows them.
module tb_alien_unit;
  import alien_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  step_period = 16'd3;
  logic [15:0]  step_dx = 16'd4;
  logic         dir_right = 1'b1;
  logic         descend = 1'b0;
  logic         hit = 1'b0;
  logic         armed = 1'b0;
  logic         fire_ack = 1'b0;
  logic [15:0]  scan_x = 16'd0;
  logic [15:0]  scan_y = 16'd0;
  logic         pixel, edge_hit, fire_req, alive;
  logic [15:0]  shot_x, shot_y, pos_x, pos_y;
  alien_state_t dbg_state;
  logic [7:0]   dbg_frame;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  logic [15:0] edge_q[$];
  logic [31:0] fire_q[$];
  logic        fire_prev = 1'b0;

  alien_unit #(.INIT_X(560), .INIT_Y(32)) dut (
    .clk(clk), .rst_n(rst_n), .step_period(step_period), .step_dx(step_dx),
    .dir_right(dir_right), .descend(descend), .hit(hit), .armed(armed),
    .fire_ack(fire_ack), .scan_x(scan_x), .scan_y(scan_y), .pixel(pixel),
    .edge_hit(edge_hit), .fire_req(fire_req), .shot_x(shot_x), .shot_y(shot_y),
    .alive(alive), .pos_x(pos_x), .pos_y(pos_y), .dbg_state_o(dbg_state),
    .dbg_frame_o(dbg_frame)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops a prediction whenever the DUT presents an edge pulse or a new fire request
  always @(negedge clk) begin
    if (rst_n) begin
      if (edge_hit === 1'b1) begin
        if (edge_q.size() == 0) chk("edge_unexpected", 32'(pos_x), 32'hFFFF_FFFF);
        else chk("edge_pos", 32'(pos_x), 32'(edge_q.pop_front()));
      end
      if (fire_req === 1'b1 && !fire_prev) begin
        if (fire_q.size() == 0) chk("fire_unexpected", cyc, 32'hFFFF_FFFF);
        else chk("fire_rise_cycle", cyc, fire_q.pop_front());
      end
    end
    fire_prev = (fire_req === 1'b1);
  end

  // driver tasks
  task automatic wait_step(output int n);
    logic [15:0] p;
    p = pos_x;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pos_x == p && n < 64);
  endtask

  task automatic step_and_check(input string name, input logic [15:0] exp_x, input logic [7:0] exp_f);
    int n;
    wait_step(n);
    chk({name, "_interval"}, 32'(n), 32'd4);
    chk({name, "_pos_x"}, 32'(pos_x), 32'(exp_x));
    chk({name, "_frame"}, 32'(dbg_frame), 32'(exp_f));
  endtask

  task automatic pix(input logic [15:0] sx, input logic [15:0] sy, input logic exp, input string name);
    scan_x = sx;
    scan_y = sy;
    @(negedge clk);
    chk(name, 32'(pixel), 32'(exp));
  endtask

  task automatic wait_fire(output int n);
    n = 0;
    while (fire_req !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_pos_x", 32'(pos_x), 32'd560);
    chk("rst_pos_y", 32'(pos_y), 32'd32);
    chk("rst_alive", 32'(alive), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'(ALIVE));
    chk("rst_frame", 32'(dbg_frame), 32'd0);
    chk("rst_fire_req", 32'(fire_req), 32'd0);
    chk("rst_edge", 32'(edge_hit), 32'd0);
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_shot_x", 32'(shot_x), 32'd592);
    chk("rst_shot_y", 32'(shot_y), 32'd96);
    rst_n = 1'b1;

    // stepping right every 4 cycles, frame toggling
    step_and_check("step1", 16'd564, 8'd1);
    step_and_check("step2", 16'd568, 8'd0);
    step_and_check("step3", 16'd572, 8'd1);

    // right bound saturates at 640-64, left bound at 0
    step_dx = 16'd20;
    edge_q.push_back(16'd576);
    step_and_check("sat_right", 16'd576, 8'd0);
    dir_right = 1'b0;
    step_dx = 16'd600;
    edge_q.push_back(16'd0);
    step_and_check("sat_left", 16'd0, 8'd1);
    dir_right = 1'b1;
    step_dx = 16'd4;
    step_and_check("step_off_edge", 16'd4, 8'd0);

    // descend coinciding with a tick, then descend alone
    repeat (3) @(negedge clk);
    descend = 1'b1;
    @(negedge clk);
    chk("desc_tick_y", 32'(pos_y), 32'd48);
    chk("desc_tick_x", 32'(pos_x), 32'd8);
    chk("desc_tick_frame", 32'(dbg_frame), 32'd1);
    @(negedge clk);
    descend = 1'b0;
    chk("desc_only_y", 32'(pos_y), 32'd64);
    chk("desc_only_x", 32'(pos_x), 32'd8);

    // pixel lookup with the alien frozen at (8,64), frame 1
    step_period = 16'hFFFF;
    step_dx = 16'd0;
    pix(16'd20,  16'd84,  1'b0, "pix_f1_r5c3");
    pix(16'd12,  16'd84,  1'b1, "pix_f1_r5c1");
    pix(16'd15,  16'd87,  1'b1, "pix_f1_r5c1_sub");
    pix(16'd7,   16'd84,  1'b0, "pix_left_of_pos");
    pix(16'd28,  16'd64,  1'b1, "pix_r0c5");
    pix(16'd67,  16'd79,  1'b1, "pix_r3c14");
    pix(16'd71,  16'd79,  1'b0, "pix_r3c15");
    pix(16'd72,  16'd64,  1'b0, "pix_relx16");
    pix(16'd12,  16'd128, 1'b0, "pix_rely16");
    step_period = 16'd0;
    @(negedge clk);
    step_period = 16'hFFFF;
    chk("one_tick_frame", 32'(dbg_frame), 32'd0);
    chk("one_tick_pos_x", 32'(pos_x), 32'd8);
    pix(16'd20,  16'd84,  1'b1, "pix_f0_r5c3");
    pix(16'd8,   16'd84,  1'b0, "pix_f0_r5c0");

    // fire handshake and cooldown
    chk("shot_x", 32'(shot_x), 32'd40);
    chk("shot_y", 32'(shot_y), 32'd128);
    armed = 1'b1;
    fire_q.push_back(cyc + 1);
    wait_fire(n);
    chk("fire_first", 32'(fire_req), 32'd1);
    repeat (4) @(negedge clk);
    fire_ack = 1'b1;
    fire_q.push_back(cyc + 4098);
    @(negedge clk);
    fire_ack = 1'b0;
    chk("fire_after_ack", 32'(fire_req), 32'd0);
    repeat (100) @(negedge clk);
    fire_ack = 1'b1;
    @(negedge clk);
    fire_ack = 1'b0;
    chk("stray_ack", 32'(fire_req), 32'd0);
    wait_fire(n);
    chk("fire_second", 32'(fire_req), 32'd1);
    armed = 1'b0;
    repeat (5) @(negedge clk);
    chk("req_kept_unarmed", 32'(fire_req), 32'd1);

    // hit with a pending request, explosion, death
    step_period = 16'd3;
    repeat (8) @(negedge clk);
    scan_x = 16'd8;
    scan_y = 16'd84;
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    chk("hit_alive", 32'(alive), 32'd0);
    chk("hit_req_drop", 32'(fire_req), 32'd0);
    chk("hit_state", 32'(dbg_state), 32'(EXPLODING));
    chk("hit_pix_alive_art", 32'(pixel), 32'd0);
    step_dx = 16'd4;
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    chk("expl_pixel", 32'(pixel), 32'd1);
    chk("expl_rehit", 32'(dbg_state), 32'(EXPLODING));
    repeat (30) @(negedge clk);
    chk("expl_still", 32'(dbg_state), 32'(EXPLODING));
    chk("expl_no_motion", 32'(pos_x), 32'd8);
    @(negedge clk);
    chk("dead_state", 32'(dbg_state), 32'(DEAD));
    armed = 1'b1;
    @(negedge clk);
    chk("dead_pixel", 32'(pixel), 32'd0);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    chk("dead_no_fire", 32'(fire_req), 32'd0);
    chk("dead_terminal", 32'(dbg_state), 32'(DEAD));

    // reset out of DEAD and again mid-explosion
    armed = 1'b0;
    step_dx = 16'd0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_from_dead", 32'(dbg_state), 32'(ALIVE));
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    chk("rehit_state", 32'(dbg_state), 32'(EXPLODING));
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_state", 32'(dbg_state), 32'(ALIVE));
    chk("rst_mid_pos_x", 32'(pos_x), 32'd560);
    chk("rst_mid_pos_y", 32'(pos_y), 32'd32);
    chk("rst_mid_alive", 32'(alive), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("edge_q_drained", 32'(edge_q.size()), 32'd0);
    chk("fire_q_drained", 32'(fire_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
